// File: rtl/aim_pkg.sv
// Shared defaults, FSM state type and constants for the aim8 feeder.
package aim_pkg;
    localparam int DEF_N  = 8;
    localparam int DEF_AW = 9;
    localparam int DEF_WW = 2;
    localparam int DEF_OW = 12;

    localparam int         ACT_MAX    = 255;
    localparam logic [1:0] WT_ILLEGAL = 2'b10;

    typedef enum logic [1:0] {
        COLLECT,
        WAIT,
        HOLD
    } state_e;
endpackage

// File: rtl/aim_relu_sat.sv
// Combinational ReLU with upper saturation from the OW-bit neuron sum to AW bits.
module aim_relu_sat
    import aim_pkg::*;
#(
    parameter int OW = DEF_OW,
    parameter int AW = DEF_AW
) (
    input  logic [OW-1:0] raw,
    output logic [AW-1:0] sat
);
    localparam logic [OW-1:0] MAX = OW'((1 << (AW - 1)) - 1);

    always_comb begin
        if (raw[OW-1]) begin
            sat = '0;
        end else if (raw > MAX) begin
            sat = AW'(MAX);
        end else begin
            sat = raw[AW-1:0];
        end
    end
endmodule

// File: rtl/aim8_feeder.sv
// Collects N activation/weight pairs into slots for the aim8 core, waits LAT
// cycles, captures the core sum and holds the saturated result until taken.
module aim8_feeder
    import aim_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int AW  = DEF_AW,
    parameter int WW  = DEF_WW,
    parameter int OW  = DEF_OW,
    parameter int LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_act,
    input  logic [WW-1:0]     in_wt,
    output logic [N*AW-1:0]   core_act,
    output logic [N*WW-1:0]   core_wt,
    input  logic [OW-1:0]     core_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [AW-1:0]     res_data,
    output logic [OW-1:0]     res_raw,
    output logic              wt_err
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          wait_q, wait_d;
    logic [N*AW-1:0]     act_q, act_d;
    logic [N*WW-1:0]     wt_q, wt_d;
    logic [OW-1:0]       raw_q, raw_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        act_d   = act_q;
        wt_d    = wt_q;
        raw_d   = raw_q;
        err_d   = err_q;

        case (state_q)
            COLLECT: begin
                if (in_valid && ready_q) begin
                    act_d[cnt_q*AW +: AW] = in_act;
                    if (in_wt == WW'(WT_ILLEGAL)) begin
                        wt_d[cnt_q*WW +: WW] = '0;
                        err_d                = 1'b1;
                    end else begin
                        wt_d[cnt_q*WW +: WW] = in_wt;
                    end
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = '0;
                        wait_d  = 4'(LAT);
                        state_d = WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            // Capture happens on the cycle after the counter reaches zero,
            // giving LAT+1 cycles from the last accept to res_valid.
            WAIT: begin
                if (wait_q == '0) begin
                    raw_d   = core_sum;
                    state_d = HOLD;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        ready_d = (state_d == COLLECT);
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            wait_q  <= '0;
            act_q   <= '0;
            wt_q    <= '0;
            raw_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            act_q   <= act_d;
            wt_q    <= wt_d;
            raw_q   <= raw_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    aim_relu_sat #(
        .OW (OW),
        .AW (AW)
    ) u_relu_sat (
        .raw (raw_q),
        .sat (res_data)
    );

    assign in_ready  = ready_q;
    assign core_act  = act_q;
    assign core_wt   = wt_q;
    assign res_raw   = raw_q;
    assign res_valid = valid_q;
    assign wt_err    = err_q;
endmodule

// File: tb/tb_aim8_feeder.sv
// Directed bench for aim8_feeder with a dot-product core model and an override value.
module tb_aim8_feeder;
    localparam int N  = 8;
    localparam int AW = 9;
    localparam int WW = 2;
    localparam int OW = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   in_act = '0;
    logic [WW-1:0]   in_wt = '0;
    logic [N*AW-1:0] core_act;
    logic [N*WW-1:0] core_wt;
    logic [OW-1:0]   core_sum;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [AW-1:0]   res_data;
    logic [OW-1:0]   res_raw;
    logic            wt_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic          use_ovr = 1'b0;
    logic [OW-1:0] ovr = '0;
    int            dot;

    aim8_feeder #(.N(N), .AW(AW), .WW(WW), .OW(OW), .LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_wt     (in_wt),
        .core_act  (core_act),
        .core_wt   (core_wt),
        .core_sum  (core_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_raw   (res_raw),
        .wt_err    (wt_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        dot = 0;
        for (int k = 0; k < N; k++)
            dot += int'($signed(core_act[k*AW +: AW])) * int'($signed(core_wt[k*WW +: WW]));
    end
    assign core_sum = use_ovr ? ovr : OW'(dot);

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] act_slot(input int k);
        return 64'($signed(core_act[k*AW +: AW]));
    endfunction

    function automatic logic signed [63:0] wt_slot(input int k);
        return 64'(core_wt[k*WW +: WW]);
    endfunction

    task automatic send(input int a, input int w, output int acc_cyc);
        int g = 0;
        in_valid = 1'b1;
        in_act   = AW'(a);
        in_wt    = WW'(w);
        while (!in_ready && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) chk("send_timeout", 64'(g), 64'(0));
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input int from_cyc, output int lat);
        int g = 0;
        while (!res_valid && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) chk("res_timeout", 64'(g), 64'(0));
        lat = cyc - from_cyc;
    endtask

    int a1[8] = '{0, 52, -41, 0, -12, 115, 95, 0};
    int w1[8] = '{1, -1, 0, 0, -1, 1, 0, -1};
    int a2[8] = '{3, -5, 7, 100, -1, 2, 0, 9};
    int w2[8] = '{1, 1, 0, 2, 1, -1, 0, 1};
    int a5[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
    int w5[8] = '{1, 1, 1, -1, 0, -1, 1, 0};

    initial begin
        int acc, last, lat, fa3, fa4, seen;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 64'(res_valid), 64'(0));
        chk("rst_err", 64'(wt_err), 64'(0));
        chk("rst_act", 64'(core_act), 64'(0));
        chk("rst_wt", 64'(core_wt), 64'(0));
        chk("rst_raw", 64'(res_raw), 64'(0));
        chk("rst_data", 64'(res_data), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(in_ready), 64'(1));

        // Neuron 1: core model yields 75 from the dot product
        for (int i = 0; i < 8; i++) send(a1[i], w1[i], last);
        chk("n1_ready_low", 64'(in_ready), 64'(0));
        wait_res(last, lat);
        chk("n1_latency", 64'(lat), 64'(2));
        chk("n1_data", 64'(res_data), 64'(75));
        chk("n1_raw", 64'($signed(res_raw)), 64'(75));
        chk("n1_slot1_act", act_slot(1), 64'(52));
        chk("n1_slot2_act", act_slot(2), -64'(41));
        chk("n1_slot1_wt", wt_slot(1), 64'(3));
        chk("n1_slot7_wt", wt_slot(7), 64'(3));
        chk("n1_err", 64'(wt_err), 64'(0));

        // Hold without handshake; result must not follow a changing core_sum
        use_ovr = 1'b1;
        ovr     = OW'(500);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(res_valid), 64'(1));
            chk("hold_data", 64'(res_data), 64'(75));
            chk("hold_raw", 64'($signed(res_raw)), 64'(75));
            chk("hold_ready", 64'(in_ready), 64'(0));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("hs_ready", 64'(in_ready), 64'(1));
        chk("hs_valid", 64'(res_valid), 64'(0));

        // res_ready in COLLECT is ignored
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("ign_valid", 64'(res_valid), 64'(0));
        chk("ign_ready", 64'(in_ready), 64'(1));
        res_ready = 1'b0;

        // Neuron 2: illegal weight in slot 3, gaps, core returns -300
        ovr = OW'(-300);
        for (int i = 0; i < 8; i++) begin
            send(a2[i], w2[i], last);
            if (i == 2) begin
                chk("keep_slot5_act", act_slot(5), 64'(115));
                chk("keep_slot7_wt", wt_slot(7), 64'(3));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_res(last, lat);
        chk("n2_slot3_wt", wt_slot(3), 64'(0));
        chk("n2_slot3_act", act_slot(3), 64'(100));
        chk("n2_err", 64'(wt_err), 64'(1));
        chk("n2_data", 64'(res_data), 64'(0));
        chk("n2_raw", 64'($signed(res_raw)), -64'(300));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Neurons 3 and 4 back-to-back with res_ready tied high
        res_ready = 1'b1;
        ovr       = OW'(900);
        for (int i = 0; i < 8; i++) begin
            send(a1[i], w1[i], acc);
            if (i == 0) fa3 = acc;
            last = acc;
        end
        wait_res(last, lat);
        chk("n3_latency", 64'(lat), 64'(2));
        chk("n3_data", 64'(res_data), 64'(255));
        chk("n3_raw", 64'($signed(res_raw)), 64'(900));
        use_ovr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(a1[i], w1[i], acc);
            if (i == 0) fa4 = acc;
            last = acc;
            if (i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        chk("b2b_period", 64'(fa4 - fa3), 64'(N + 1 + 2));
        wait_res(last, lat);
        chk("n4_gap_data", 64'(res_data), 64'(75));
        chk("n4_err_sticky", 64'(wt_err), 64'(1));
        @(negedge clk);
        res_ready = 1'b0;

        // Reset mid-collection
        for (int i = 0; i < 5; i++) send(a2[i], w1[i], last);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_act", 64'(core_act), 64'(0));
        chk("mid_rst_err", 64'(wt_err), 64'(0));
        chk("mid_rst_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        chk("mid_rst_no_valid", 64'(seen), 64'(0));
        send(a5[0], w5[0], last);
        chk("restart_slot0", act_slot(0), 64'(10));
        chk("restart_slot1", act_slot(1), 64'(0));
        for (int i = 1; i < 8; i++) send(a5[i], w5[i], last);
        wait_res(last, lat);
        chk("n5_latency", 64'(lat), 64'(2));
        chk("n5_data", 64'(res_data), 64'(30));
        chk("n5_err", 64'(wt_err), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
